uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with an oversampling tick, optional parity and 1-2 stop bits.
// A frame with a low stop bit parks in WAIT_HIGH until the line idles, so a break yields one frame.
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_MID     = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic          P_ODD     = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              pperr_q, pperr_d;
    logic              pferr_q, pferr_d;
    logic              done_q, done_d;
    logic              sync1_q, sync2_q;
    logic              rx_i;
    logic              stop_fe;

    assign rx_i = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pperr_q <= 1'b0;
            pferr_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            pperr_q <= pperr_d;
            pferr_q <= pferr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        pperr_d = pperr_q;
        pferr_d = pferr_q;
        done_d  = 1'b0;
        stop_fe = pferr_q | ~rx_i;
        case (state_q)
            IDLE: begin
                if (!rx_i) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_i) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                            pperr_d = 1'b0;
                            pferr_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_i, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            n_d     = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        pperr_d = ((^b_q) ^ rx_i) != P_ODD;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        pferr_d = stop_fe;
                        if (n_q == STOP_LAST) begin
                            // results publish together with the done pulse
                            n_d     = '0;
                            done_d  = 1'b1;
                            dout_d  = b_q;
                            perr_d  = pperr_q;
                            ferr_d  = stop_fe;
                            state_d = stop_fe ? WAIT_HIGH : IDLE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);

endmodule
